memoria_datos: RTL and testbench



---
 rtl/memoria_datos_pkg.sv | 24 ++
 rtl/memoria_datos_if.sv | 25 ++
 rtl/memoria_datos_array.sv | 28 ++
 rtl/memoria_datos.sv | 174 +++++++++++++++++
 tb/tb_memoria_datos.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/memoria_datos_pkg.sv
// Shared types and helpers for the memoria_datos data memory.
// Holds the controller state encoding, the wait counter width and an index-width helper.
package memoria_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam int WCNT_W = 4;

   // Minimum of 1 so a single-word array still has an index bit.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((64'd1 << w) < 64'(value)) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/memoria_datos_if.sv
// Request/response bus between the load/store unit and memoria_datos.
// The requester drives req/we/addr/wdata; the memory answers with rdata/ack/err/busy.
interface memoria_datos_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;
   logic              err;
   logic              busy;

   modport master (
      output req, we, addr, wdata,
      input  rdata, ack, err, busy
   );

   modport slave (
      input  req, we, addr, wdata,
      output rdata, ack, err, busy
   );
endinterface

// File: rtl/memoria_datos_array.sv
// Single-port DEPTH x DATA_W storage with synchronous write and synchronous read.
// q only changes on an enabled read, so it holds the last word read.
module memoria_array #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 126,
   parameter int IDX_W  = 7
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[idx] <= wdata;
         end else begin
            q <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/memoria_datos.sv
// Handshaked data memory: post-reset clear sequence, programmable wait states,
// req/ack protocol and out-of-range detection in front of a single-port array.
//
// state | meaning
// CLEAR | writes INIT0 to word 0 and zero to the rest, one word per edge
// IDLE  | waits for req
// WAIT  | counts wait states down in wcnt
// RESP  | ack high for one cycle, err valid
module memoria_datos
   import memoria_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 16,
   parameter int DEPTH          = 126,
   parameter int WAIT_STATES    = 0,
   parameter int CLEAR_ON_RESET = 1,
   parameter int INIT0          = 32761
) (
   input  logic            clk,
   input  logic            rst_n,
   memoria_datos_if.slave  bus
);

   localparam int                IDX_W    = clog2(DEPTH);
   localparam logic [IDX_W-1:0]  PTR_LAST = IDX_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);
   localparam logic [DATA_W-1:0] INIT_W   = DATA_W'(INIT0);
   localparam logic [WCNT_W-1:0] WS_LOAD  = WCNT_W'(WAIT_STATES - 1);
   localparam bit                NO_WAIT  = (WAIT_STATES == 0);
   localparam bit                DO_CLEAR = (CLEAR_ON_RESET != 0);

   localparam logic [1:0] S_CLEAR = CLEAR;
   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_WAIT  = WAIT;
   localparam logic [1:0] S_RESP  = RESP;

   logic [1:0]        state;
   logic [IDX_W-1:0]  ptr;
   logic [WCNT_W-1:0] wcnt;

   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              rd_zero;
   logic              err_q;

   logic              cur_we;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic              in_range;
   logic              do_access;
   logic              clearing;

   logic              arr_en;
   logic              arr_we;
   logic [IDX_W-1:0]  arr_idx;
   logic [DATA_W-1:0] arr_wdata;
   logic [DATA_W-1:0] arr_q;

   // With no wait states the access happens on the accepting edge, so the live bus is used.
   always_comb begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      if (state == S_IDLE) begin
         cur_we    = bus.we;
         cur_addr  = bus.addr;
         cur_wdata = bus.wdata;
      end
   end

   assign in_range  = ({1'b0, cur_addr} < DEPTH_A);
   assign clearing  = rst_n && (state == S_CLEAR);
   assign do_access = rst_n &&
                      (((state == S_IDLE) && bus.req && NO_WAIT) ||
                       ((state == S_WAIT) && (wcnt == '0)));

   // The clear pointer and the request address share the single array port.
   always_comb begin
      arr_en    = 1'b0;
      arr_we    = 1'b0;
      arr_idx   = cur_addr[IDX_W-1:0];
      arr_wdata = cur_wdata;
      if (clearing) begin
         arr_en    = 1'b1;
         arr_we    = 1'b1;
         arr_idx   = ptr;
         arr_wdata = (ptr == '0) ? INIT_W : '0;
      end else if (do_access && in_range) begin
         arr_en    = 1'b1;
         arr_we    = cur_we;
      end
   end

   memoria_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (arr_en),
      .we    (arr_we),
      .idx   (arr_idx),
      .wdata (arr_wdata),
      .q     (arr_q)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= DO_CLEAR ? S_CLEAR : S_IDLE;
         ptr     <= '0;
         wcnt    <= '0;
         rd_zero <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         case (state)
            S_CLEAR: begin
               ptr <= ptr + 1'b1;
               if (ptr == PTR_LAST) begin
                  ptr   <= '0;
                  state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (bus.req) begin
                  if (NO_WAIT) begin
                     state <= S_RESP;
                  end else begin
                     wcnt  <= WS_LOAD;
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (wcnt != '0) begin
                  wcnt <= wcnt - 1'b1;
               end else begin
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
               err_q <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase

         // rd_zero masks the array output so rdata reads 0 after reset and out-of-range hits.
         if (do_access) begin
            err_q <= !in_range;
            if (!in_range) begin
               rd_zero <= 1'b1;
            end else if (!cur_we) begin
               rd_zero <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if ((state == S_IDLE) && bus.req) begin
         we_q    <= bus.we;
         addr_q  <= bus.addr;
         wdata_q <= bus.wdata;
      end
   end

   assign bus.rdata = rd_zero ? '0 : arr_q;
   assign bus.ack   = (state == S_RESP);
   assign bus.err   = err_q && (state == S_RESP);
   assign bus.busy  = (state != S_IDLE);

endmodule

// File: tb/tb_memoria_datos.sv
// Directed bench for memoria_datos: three instances cover no wait states, three wait
// states with clear, and three wait states without clear.
module tb_memoria_datos;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_v   [3];
   logic        req_v   [3];
   logic        we_v    [3];
   logic [15:0] addr_v  [3];
   logic [15:0] wdata_v [3];
   logic [15:0] rdata_v [3];
   logic        ack_v   [3];
   logic        err_v   [3];
   logic        busy_v  [3];

   memoria_datos_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
   memoria_datos_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();
   memoria_datos_if #(.DATA_W(16), .ADDR_W(16)) bus2 ();

   assign bus0.req = req_v[0];  assign bus0.we = we_v[0];
   assign bus0.addr = addr_v[0]; assign bus0.wdata = wdata_v[0];
   assign bus1.req = req_v[1];  assign bus1.we = we_v[1];
   assign bus1.addr = addr_v[1]; assign bus1.wdata = wdata_v[1];
   assign bus2.req = req_v[2];  assign bus2.we = we_v[2];
   assign bus2.addr = addr_v[2]; assign bus2.wdata = wdata_v[2];

   assign rdata_v[0] = bus0.rdata; assign ack_v[0] = bus0.ack;
   assign err_v[0]   = bus0.err;   assign busy_v[0] = bus0.busy;
   assign rdata_v[1] = bus1.rdata; assign ack_v[1] = bus1.ack;
   assign err_v[1]   = bus1.err;   assign busy_v[1] = bus1.busy;
   assign rdata_v[2] = bus2.rdata; assign ack_v[2] = bus2.ack;
   assign err_v[2]   = bus2.err;   assign busy_v[2] = bus2.busy;

   memoria_datos #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_v[0]), .bus(bus0));
   memoria_datos #(.WAIT_STATES(3)) dut1 (.clk(clk), .rst_n(rst_v[1]), .bus(bus1));
   memoria_datos #(.WAIT_STATES(3), .CLEAR_ON_RESET(0)) dut2 (.clk(clk), .rst_n(rst_v[2]), .bus(bus2));

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One request; lat counts cycles from the accepting edge to the ack cycle (-1 on timeout).
   task automatic access(input int d, input logic w, input logic [15:0] a, input logic [15:0] wd,
                         output int lat, output int busy_n, output logic [15:0] rd, output logic e);
      bit done;
      @(negedge clk);
      req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd;
      @(posedge clk);
      #1 req_v[d] = 1'b0;
      lat = 0; busy_n = 0; rd = '0; e = 1'b0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         lat++;
         if (busy_v[d]) busy_n++;
         if (ack_v[d]) begin
            rd = rdata_v[d];
            e = err_v[d];
            done = 1'b1;
         end
      end
      if (!done) lat = -1;
      else begin
         @(negedge clk);
         check("ack_one_cycle", {31'd0, ack_v[d]}, 32'd0);
      end
   endtask

   typedef struct {
      int          d;
      logic        w;
      logic [15:0] a;
      logic [15:0] wd;
      logic [15:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      logic        chk_rd;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int lat, busy_n, n, acks, cyc, last;
      logic [15:0] rd;
      logic e;

      #200_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, busy_n, n, acks, cyc, last;
      logic [15:0] rd;
      logic e;

      // dut0: no wait states, cleared array
      vecs.push_back('{0, 1'b0, 16'd0,     16'h0000, 16'h7FF9, 1'b0, 1, 1'b1});
      vecs.push_back('{0, 1'b0, 16'd125,   16'h0000, 16'h0000, 1'b0, 1, 1'b1});
      vecs.push_back('{0, 1'b0, 16'd9,     16'h0000, 16'h0000, 1'b0, 1, 1'b1});
      vecs.push_back('{0, 1'b1, 16'd7,     16'hBEEF, 16'h0000, 1'b0, 1, 1'b1});
      vecs.push_back('{0, 1'b0, 16'd7,     16'h0000, 16'hBEEF, 1'b0, 1, 1'b1});
      vecs.push_back('{0, 1'b1, 16'd126,   16'h1234, 16'h0000, 1'b1, 1, 1'b1});
      vecs.push_back('{0, 1'b0, 16'd126,   16'h0000, 16'h0000, 1'b1, 1, 1'b1});
      vecs.push_back('{0, 1'b0, 16'd125,   16'h0000, 16'h0000, 1'b0, 1, 1'b1});
      vecs.push_back('{0, 1'b0, 16'd7,     16'h0000, 16'hBEEF, 1'b0, 1, 1'b1});
      vecs.push_back('{0, 1'b1, 16'd128,   16'hAAAA, 16'h0000, 1'b1, 1, 1'b1});
      vecs.push_back('{0, 1'b0, 16'd0,     16'h0000, 16'h7FF9, 1'b0, 1, 1'b1});
      vecs.push_back('{0, 1'b0, 16'hFFFF,  16'h0000, 16'h0000, 1'b1, 1, 1'b1});
      vecs.push_back('{0, 1'b1, 16'd8,     16'h1357, 16'h0000, 1'b0, 1, 1'b1});
      vecs.push_back('{0, 1'b0, 16'd8,     16'h0000, 16'h1357, 1'b0, 1, 1'b1});
      // dut1: three wait states
      vecs.push_back('{1, 1'b0, 16'd0,     16'h0000, 16'h7FF9, 1'b0, 4, 1'b1});
      vecs.push_back('{1, 1'b1, 16'd5,     16'h0A0A, 16'h7FF9, 1'b0, 4, 1'b1});
      vecs.push_back('{1, 1'b0, 16'd5,     16'h0000, 16'h0A0A, 1'b0, 4, 1'b1});
      // dut2: three wait states, no clear
      vecs.push_back('{2, 1'b1, 16'd3,     16'h00C3, 16'h0000, 1'b0, 4, 1'b1});
      vecs.push_back('{2, 1'b0, 16'd3,     16'h0000, 16'h00C3, 1'b0, 4, 1'b1});
      vecs.push_back('{2, 1'b0, 16'd126,   16'h0000, 16'h0000, 1'b1, 4, 1'b1});

      for (int i = 0; i < 3; i++) begin
         rst_v[i] = 1'b0; req_v[i] = 1'b0; we_v[i] = 1'b0;
         addr_v[i] = '0; wdata_v[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rdata", {16'd0, rdata_v[0]}, 32'd0);
      check("rst_ack",   {31'd0, ack_v[0]},   32'd0);
      check("rst_err",   {31'd0, err_v[0]},   32'd0);
      check("rst_busy_clear",   {31'd0, busy_v[0]}, 32'd1);
      check("rst_busy_noclear", {31'd0, busy_v[2]}, 32'd0);

      // Clear duration, with a write request to addr 9 pulsed mid-clear
      for (int i = 0; i < 3; i++) rst_v[i] = 1'b1;
      n = 0; acks = 0;
      while (busy_v[0] && n < 1000) begin
         if (n == 50) begin
            req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 16'd9; wdata_v[0] = 16'h9999;
         end else begin
            req_v[0] = 1'b0;
         end
         @(posedge clk);
         n++;
         @(negedge clk);
         if (ack_v[0]) acks++;
      end
      req_v[0] = 1'b0;
      check("clear_edges", n, 126);
      check("clear_no_ack", acks, 0);

      foreach (vecs[i]) begin
         access(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, lat, busy_n, rd, e);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
         if (vecs[i].chk_rd)
            check($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp_rd});
      end

      // Busy spans the whole wait+response window with three wait states
      access(1, 1'b0, 16'd0, 16'h0, lat, busy_n, rd, e);
      check("ws3_busy_cycles", busy_n, 4);
      check("ws3_lat", lat, 4);

      // req held high: one ack every five cycles
      @(negedge clk);
      req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 16'd0;
      cyc = 0; last = -1; acks = 0;
      for (int i = 0; i < 40 && acks < 4; i++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (ack_v[1]) begin
            if (last >= 0) check("b2b_spacing", cyc - last, 5);
            last = cyc;
            acks++;
         end
      end
      req_v[1] = 1'b0;
      check("b2b_acks", acks, 4);

      // Write request pulsed during WAIT is dropped
      @(negedge clk);
      @(negedge clk);
      req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 16'd5;
      @(posedge clk);
      #1 req_v[1] = 1'b0;
      @(negedge clk);
      req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 16'd6; wdata_v[1] = 16'h6666;
      @(negedge clk);
      req_v[1] = 1'b0;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         if (ack_v[1]) acks++;
         @(negedge clk);
      end
      check("wait_req_ignored_acks", acks, 1);
      access(1, 1'b0, 16'd6, 16'h0, lat, busy_n, rd, e);
      check("wait_req_no_write", {16'd0, rd}, 32'd0);

      // Reset during WAIT of a write, clear enabled
      @(negedge clk);
      req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 16'd3; wdata_v[1] = 16'h5555;
      @(posedge clk);
      #1 req_v[1] = 1'b0;
      @(negedge clk);
      rst_v[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      acks = 0;
      if (ack_v[1]) acks++;
      rst_v[1] = 1'b1;
      n = 0;
      while (busy_v[1] && n < 1000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (ack_v[1]) acks++;
      end
      check("midop_no_ack", acks, 0);
      check("midop_clear_edges", n, 126);
      access(1, 1'b0, 16'd3, 16'h0, lat, busy_n, rd, e);
      check("midop_addr3_cleared", {16'd0, rd}, 32'd0);

      // Reset during WAIT of a write, no clear: contents retained, idle at once
      @(negedge clk);
      req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 16'd3; wdata_v[2] = 16'h5555;
      @(posedge clk);
      #1 req_v[2] = 1'b0;
      @(negedge clk);
      rst_v[2] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("noclr_busy_in_reset", {31'd0, busy_v[2]}, 32'd0);
      acks = 0;
      if (ack_v[2]) acks++;
      rst_v[2] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ack_v[2]) acks++;
      end
      check("noclr_no_ack", acks, 0);
      access(2, 1'b0, 16'd3, 16'h0, lat, busy_n, rd, e);
      check("noclr_addr3_kept", {16'd0, rd}, 32'h00C3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
